// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage data-bus handshake with stall, timeout abort and MEM/WB register
module mem_stage_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        ErrM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPlus4W
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, nextState;
    logic [7:0] waitCnt;
    logic memOp, timeoutHit, loadDone;
    assign memOp      = MemWriteM | (ResultSrcM == 2'b01);
    assign timeoutHit = (state == BUSY) & ~dmem_ack & (waitCnt == 8'(TIMEOUT));
    assign loadDone   = dmem_req & dmem_ack & (ResultSrcM == 2'b01);
    // The pipeline is frozen while stalled, so the pass-through stays stable on its own
    assign dmem_we    = MemWriteM;
    assign dmem_addr  = ALUResultM;
    assign dmem_wdata = WriteDataM;
    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end
    // Next state: enter BUSY on an unacknowledged access, leave on ack or timeout
    always_comb begin
        nextState = (state == IDLE) ? ((memOp & ~dmem_ack) ? BUSY : IDLE)
                                    : ((dmem_ack | timeoutHit) ? IDLE : BUSY);
    end
    // Outputs: request and stall derived from state and the current handshake
    always_comb begin
        dmem_req = ((state == IDLE) & memOp) | (state == BUSY);
        StallM   = (state == IDLE) ? (memOp & ~dmem_ack) : (~dmem_ack & ~timeoutHit);
    end
    // Wait counter: cleared while idle so it starts at zero on entry to BUSY
    always_ff @(posedge clk) begin
        if (reset || state == IDLE) waitCnt <= 8'd0;
        else if (!dmem_ack && !timeoutHit) waitCnt <= waitCnt + 8'd1;
    end
    // Timeout pulse, high for the single cycle after an abort
    always_ff @(posedge clk) begin
        if (reset) ErrM <= 1'b0;
        else       ErrM <= timeoutHit;
    end
    // MEM/WB register: bubble while stalled, aborted accesses never write back
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= 32'd0;
            ReadDataW  <= 32'd0;
            RdW        <= 5'd0;
            PCPlus4W   <= 32'd0;
        end else if (StallM) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
        end else begin
            RegWriteW  <= RegWriteM & ~timeoutHit;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
            if (loadDone) ReadDataW <= dmem_rdata;
        end
    end
endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max BUSY cycles waited for dmem_ack before abort (1..255).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port RegWriteM  input  1  register write enable from EX/MEM.
REQ-005 SHALL have port MemWriteM  input  1  store enable from EX/MEM.
REQ-006 SHALL have port ResultSrcM  input  2  result select from EX/MEM; 2'b01 means load.
REQ-007 SHALL have port ALUResultM  input  32  effective address or ALU result.
REQ-008 SHALL have port WriteDataM  input  32  store data.
REQ-009 SHALL have port RdM  input  5  destination register.
REQ-010 SHALL have port PCPlus4M  input  32  PC+4 for link results.
REQ-011 SHALL have port dmem_req  output  1  data bus request.
REQ-012 SHALL have port dmem_we  output  1  bus write strobe.
REQ-013 SHALL have port dmem_addr  output  32  bus address.
REQ-014 SHALL have port dmem_wdata  output  32  bus write data.
REQ-015 SHALL have port dmem_ack  input  1  bus completion; read data is valid in the same cycle.
REQ-016 SHALL have port dmem_rdata  input  32  bus read data.
REQ-017 SHALL have port StallM  output  1  freezes IF through EX/MEM registers.
REQ-018 SHALL have port ErrM  output  1  one-cycle timeout pulse.
REQ-019 SHALL have ports RegWriteW (1), ResultSrcW (2), ALUResultW (32), ReadDataW (32), RdW (5), PCPlus4W (32), all outputs forming the MEM/WB register.

Function
REQ-020 SHALL define memop = MemWriteM | (ResultSrcM == 2'b01).
REQ-021 SHALL implement FSM states IDLE and BUSY.
REQ-022 SHALL drive dmem_req = (IDLE & memop) | BUSY, combinationally.
REQ-023 SHALL drive dmem_we = MemWriteM, dmem_addr = ALUResultM, dmem_wdata = WriteDataM, with the pass-through held stable while StallM=1.
REQ-024 SHALL keep StallM=0 and load the MEM/WB register with the M-stage values at each clock edge when in IDLE with memop=0.
REQ-025 SHALL complete with zero stall when in IDLE with memop=1 and dmem_ack=1: stay IDLE, StallM=0, MEM/WB loads, ReadDataW <= dmem_rdata.
REQ-026 SHALL move to BUSY when in IDLE with memop=1 and dmem_ack=0, with StallM=1 in that cycle.
REQ-027 SHALL assert StallM=1 in BUSY while dmem_ack=0.
REQ-028 SHALL load a bubble into MEM/WB whenever StallM=1: RegWriteW=0 and ResultSrcW=0, data fields unchanged.
REQ-029 SHALL, in BUSY with dmem_ack=1, return to IDLE with StallM=0, load MEM/WB from the M-stage values, and set ReadDataW <= dmem_rdata.
REQ-030 SHALL clear an 8-bit wait counter on entry to BUSY and increment it for each BUSY cycle without ack.
REQ-031 SHALL, when the counter equals TIMEOUT with no ack, return to IDLE, pulse ErrM=1 for one cycle, drop StallM, and load MEM/WB with RegWriteW=0.
REQ-032 SHALL give dmem_ack priority over timeout when both occur in the same cycle: normal completion, ErrM=0.
REQ-033 SHALL ignore dmem_ack in IDLE when memop=0.
REQ-034 SHALL hold ReadDataW unchanged on cycles with no load completion.

Reset
REQ-035 SHALL, with reset=1 at a clock edge, force state=IDLE, wait counter=0, ErrM=0, and all W outputs to 0, overriding any in-flight transaction.
REQ-036 SHALL treat outputs during reset as derived from state=IDLE: dmem_req follows memop combinationally; the bus tolerates a request with no completion.

Verification
REQ-037 SHALL verify ALU op: RegWriteM=1, ResultSrcM=00, ALUResultM=0x10 -> next cycle RegWriteW=1, ALUResultW=0x10, StallM never 1.
REQ-038 SHALL verify zero-wait load: ResultSrcM=01, ALUResultM=0x100, ack in the same cycle with rdata=0xDEADBEEF -> ReadDataW=0xDEADBEEF, no stall.
REQ-039 SHALL verify 3-wait store: MemWriteM=1, ack on the 4th cycle -> StallM=1 for 3 cycles, 3 bubbles with RegWriteW=0, dmem_we/addr/wdata stable throughout.
REQ-040 SHALL verify timeout: TIMEOUT=4, load with no ack -> ErrM pulses once after 4 BUSY cycles, RegWriteW=0, state back to IDLE.
REQ-041 SHALL verify reset in BUSY: reset pulsed on the 2nd wait cycle -> next cycle IDLE, all W outputs 0, and a subsequent load completes normally.
